lsu_mem_ctrl: RTL

Load/store memory controller for the MEM stage. It takes the load/store command from EX/MEM and runs a single-outstanding request/grant/response handshake with data memory. For stores it generates byte enables and lane-shifted write data. For loads it captures the raw 32-bit read word and its address, which the MEM-stage read alignment logic consumes. It stalls the pipeline for the duration of every access.

---
 rtl/lsu_mem_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: single-outstanding req/gnt/rvalid handshake.
// Optional `MISALIGN_TRAP_EN: word-crossing accesses pulse misalign instead of issuing.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       dataout,
  output logic [ADDR_W-1:0] addr_q,
  output logic [4:0]        mem_op_q,
  output logic              done,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              stall
);

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      MEM_BYTE: be = 4'b0001 << a;
      MEM_HALF: be = 4'b0011 << a;
      MEM_WORD: be = 4'b1111;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Lanes shifted past byte 3 fall off the top of the 32-bit word.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] wd;
    case (size)
      MEM_BYTE: wd = {4{d[7:0]}};
      MEM_HALF: wd = {16'h0000, d[15:0]} << {a, 3'b000};
      MEM_WORD: wd = d;
      default:  wd = d;
    endcase
    return wd;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = (a == 2'd3);
      MEM_WORD: bad = (a != 2'd0);
      default:  bad = (a != 2'd0);
    endcase
    return bad;
  endfunction
`endif

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         dwdata_q, dwdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
  logic [4:0]          op_lat_q, op_lat_d;
  logic                done_q, done_d;
  logic                op_valid_s;
  logic                accept_s;

  // Exactly one of load/store marks a real command; anything else is a no-op.
  assign op_valid_s = start && (mem_op[3] ^ mem_op[4]) && (state_q == S_IDLE);

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic trap_s;
  assign trap_s   = op_valid_s && crosses_word(mem_op[1:0], addr[1:0]);
  assign accept_s = op_valid_s && !trap_s;
  assign misalign = misalign_q;
`else
  assign accept_s = op_valid_s;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      daddr_q    <= '0;
      be_q       <= 4'b0000;
      dwdata_q   <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      addr_lat_q <= '0;
      op_lat_q   <= 5'b00000;
      done_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      daddr_q    <= daddr_d;
      be_q       <= be_d;
      dwdata_q   <= dwdata_d;
      rdata_q    <= rdata_d;
      addr_lat_q <= addr_lat_d;
      op_lat_q   <= op_lat_d;
      done_q     <= done_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_REQ;
        else          state_d = S_IDLE;
      end
      S_REQ: begin
        if (dmem_gnt) state_d = op_lat_q[4] ? S_DONE : S_WAIT;
        else          state_d = S_REQ;
      end
      S_WAIT: begin
        if (dmem_rvalid) state_d = S_DONE;
        else             state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered memory-side and aligner-side outputs
  always_comb begin
    if (accept_s) begin
      we_d       = mem_op[4];
      daddr_d    = {addr[ADDR_W-1:2], 2'b00};
      be_d       = lane_be(mem_op[1:0], addr[1:0]);
      dwdata_d   = lane_wdata(mem_op[1:0], addr[1:0], wdata);
      addr_lat_d = addr;
      op_lat_d   = mem_op;
    end else begin
      we_d       = we_q;
      daddr_d    = daddr_q;
      be_d       = be_q;
      dwdata_d   = dwdata_q;
      addr_lat_d = addr_lat_q;
      op_lat_d   = op_lat_q;
    end
    if ((state_q == S_WAIT) && dmem_rvalid) rdata_d = dmem_rdata;
    else                                    rdata_d = rdata_q;
    req_d  = (state_d == S_REQ);
    done_d = (state_d == S_DONE);
`ifdef MISALIGN_TRAP_EN
    misalign_d = trap_s;
`endif
  end

  // Outputs; stall also covers the IDLE cycle in which a command is accepted
  always_comb begin
    stall      = accept_s || (state_q == S_REQ) || (state_q == S_WAIT);
    dmem_req   = req_q;
    dmem_we    = we_q;
    dmem_addr  = daddr_q;
    dmem_be    = be_q;
    dmem_wdata = dwdata_q;
    dataout    = rdata_q;
    addr_q     = addr_lat_q;
    mem_op_q   = op_lat_q;
    done       = done_q;
  end

endmodule
